// File: rtl/led_pio_sequencer.sv
// led_pio_sequencer: plays a table of up to 4 LED patterns to an 8-bit LED PIO,
// one Avalon-MM write every max(PERIOD,1)+1 cycles, configured by the CPU
// through its own Avalon-MM slave.
//
// Ports:
//   clk, reset_n                   system clock, async active-low reset
//   s_address/s_chipselect/
//   s_write_n/s_writedata          config slave writes (one clk to take effect)
//   s_readdata                     config slave read data, combinational, no wait states
//   m_chipselect/m_write_n/
//   m_address/m_writedata          PIO master (writes only, address fixed at 0)
//   m_waitrequest                  PIO stall; request held stable while high
//   busy                           high while the sequencer FSM is not IDLE
//
// Register map: 0 CONTROL {len-1[3:2], oneshot[1], enable[0]}, 1 PERIOD,
// 2 STATUS {index[3:2], done[1], busy[0]} (any write clears done),
// 3 reserved (reads 0), 4..7 PATTERN[0..3].

module led_pio_sequencer #(
  parameter int PERIOD_W = 24,
  parameter int LED_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [1:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Configuration registers
  logic                en_q;
  logic                oneshot_q;
  logic [1:0]          len_m1_q;
  logic [PERIOD_W-1:0] period_q;
  logic [LED_W-1:0]    pattern_q [4];

  // Sequencer state
  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0]    wdat_q, wdat_d;
  logic                done_q;
  logic                done_set, done_clr_run;
  logic                en_prev_q;
  logic                start_pend_q, start_pend_d;
  logic                abort_q, abort_d;

  logic                slv_wr;
  logic                en_rise;
  logic                start_req;
  logic [1:0]          idx_next;
  logic [PERIOD_W-1:0] cnt_reload;

  // Upper write-data bits are not stored anywhere.
  logic unused_wdata_hi;
  assign unused_wdata_hi = &{1'b0, s_writedata[31:PERIOD_W]};

  assign slv_wr = s_chipselect & ~s_write_n;

  // Start is keyed off the registered enable edge. A rising edge seen while a
  // transfer is still draining is remembered so it can restart from IDLE.
  assign en_rise   = en_q & ~en_prev_q;
  assign start_req = (en_rise | start_pend_q) & en_q;

  // Using >= rather than == means a shrunk len with index already past the end
  // still wraps to 0 on the next advance.
  assign idx_next   = (idx_q >= len_m1_q) ? 2'd0 : idx_q + 2'd1;
  assign cnt_reload = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  //--------------------------------------------------------------------------
  // Config slave registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      len_m1_q  <= 2'd0;
      period_q  <= '0;
      for (int i = 0; i < 4; i++) pattern_q[i] <= '0;
    end else if (slv_wr) begin
      case (s_address)
        3'd0: begin
          en_q      <= s_writedata[0];
          oneshot_q <= s_writedata[1];
          len_m1_q  <= s_writedata[3:2];
        end
        3'd1:    period_q <= s_writedata[PERIOD_W-1:0];
        3'd4, 3'd5, 3'd6, 3'd7:
                 pattern_q[s_address[1:0]] <= s_writedata[LED_W-1:0];
        default: ; // STATUS side effect handled with done; address 3 ignored
      endcase
    end
  end

  always_comb begin
    s_readdata = 32'd0;
    case (s_address)
      3'd0:    s_readdata = {28'd0, len_m1_q, oneshot_q, en_q};
      3'd1:    s_readdata = {{(32-PERIOD_W){1'b0}}, period_q};
      3'd2:    s_readdata = {28'd0, idx_q, done_q, busy};
      3'd4, 3'd5, 3'd6, 3'd7:
               s_readdata = {{(32-LED_W){1'b0}}, pattern_q[s_address[1:0]]};
      default: s_readdata = 32'd0;
    endcase
  end

  //--------------------------------------------------------------------------
  // Sequencer FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      wdat_q       <= '0;
      done_q       <= 1'b0;
      en_prev_q    <= 1'b0;
      start_pend_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wdat_q       <= wdat_d;
      en_prev_q    <= en_q;
      start_pend_q <= start_pend_d;
      abort_q      <= abort_d;
      if (done_set)
        done_q <= 1'b1;
      else if (done_clr_run || (slv_wr && s_address == 3'd2))
        done_q <= 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    wdat_d       = wdat_q;
    done_set     = 1'b0;
    done_clr_run = 1'b0;
    abort_d      = 1'b0;
    // Pending start only accumulates while away from IDLE.
    start_pend_d = (state_q == ST_IDLE) ? 1'b0 : (start_pend_q | en_rise);

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d      = ST_WRITE;
          idx_d        = 2'd0;
          wdat_d       = pattern_q[0];
          done_clr_run = 1'b1;
        end
      end

      ST_WRITE: begin
        if (!m_waitrequest) begin
          idx_d = idx_next;
          if (abort_q || !en_q) begin
            // Disabled during the transfer: finish it, but never flag done.
            state_d = ST_IDLE;
          end else if (oneshot_q && idx_q == len_m1_q) begin
            state_d  = ST_IDLE;
            done_set = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_reload;
          end
        end else begin
          // Remember any disable seen while stalled, even if re-enabled later.
          abort_d = abort_q | ~en_q;
        end
      end

      ST_WAIT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_WRITE;
          wdat_d  = pattern_q[idx_q];
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Master outputs: decoded straight from the state register so an async
  // reset drops the bus immediately.
  //--------------------------------------------------------------------------
  assign busy         = (state_q != ST_IDLE);
  assign m_chipselect = (state_q == ST_WRITE);
  assign m_write_n    = ~(state_q == ST_WRITE);
  assign m_address    = 2'b00;
  assign m_writedata  = (state_q == ST_WRITE) ? {{(32-LED_W){1'b0}}, wdat_q} : 32'd0;

endmodule

// File: doc/led_pio_sequencer.md
Name: led_pio_sequencer

Overview:
Hardware pattern sequencer that owns the master side of the 8-bit LED PIO slave. It periodically writes a programmable table of up to 4 LED patterns to that PIO, so the Nios CPU does not have to bit-bang status displays while the PID loop runs. The CPU configures it through its own Avalon-MM slave. Its Avalon-MM master drives the PIO's chipselect/write_n/address/writedata.

Parameters:
PERIOD_W, 24, width of PERIOD register / tick counter (cycles between pattern steps)
LED_W, 8, width of each pattern entry and of the PIO data field

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
s_address  input  3  config slave word address
s_chipselect  input  1  config slave select
s_write_n  input  1  config slave write strobe, active-low
s_writedata  input  32  config slave write data
s_readdata  output  32  config slave read data, combinational from s_address, zero wait states
m_chipselect  output  1  PIO master select
m_write_n  output  1  PIO master write strobe, active-low
m_address  output  2  PIO master address, always 0 (data register)
m_writedata  output  32  PIO write data, {24'b0, pattern}
m_waitrequest  input  1  PIO stall, tie 0 for zero-wait PIO
busy  output  1  high while the FSM is not IDLE

Behaviour:
- Reset: all registers 0; FSM=IDLE; m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0.
- Register map (s_address): 0 CONTROL, 1 PERIOD, 2 STATUS, 4..7 PATTERN[0..3]. Addresses 3 and 4..7 with unused bits read back zero-extended; address 3 reads 0, writes ignored.
- CONTROL: [0] enable, [1] oneshot, [3:2] len-1 (active entries 0..len-1). Other bits read 0.
- PERIOD: [PERIOD_W-1:0]; value 0 treated as 1.
- STATUS, read-only: [0] busy, [1] done, [3:2] current index. Any write to address 2 clears done.
- PATTERN[i]: [LED_W-1:0].
- Slave writes occur when s_chipselect && !s_write_n. They take effect on the next clk edge.
- FSM states: IDLE, WRITE, WAIT.
  - IDLE -> WRITE: the cycle after enable goes 0->1 (register edge). Index reset to 0, done cleared.
  - WRITE: m_chipselect=1, m_write_n=0, m_writedata=PATTERN[index]. The write is accepted on an edge where m_waitrequest=0. Outputs hold stable while m_waitrequest=1.
  - On acceptance:
    - If oneshot and index==len-1: go to IDLE, set done, release the bus.
    - Otherwise: go to WAIT, load counter=max(PERIOD,1)-1, index advances (wraps len-1 -> 0).
  - WAIT: bus idle (chipselect=0, write_n=1). Counter decrements each cycle. When counter==0, go to WRITE.
- Spacing between accepted writes with no stalls = max(PERIOD,1)+1 cycles.
- PATTERN[index] is sampled when WRITE is entered and held for the whole transfer. PATTERN/PERIOD/len writes during a run apply at the next WRITE entry / counter reload.
- Disable (enable 1->0) mid-run:
  - In WAIT: go to IDLE next cycle.
  - In WRITE: the in-flight transfer completes (never aborted), then go to IDLE.
  - done is not set on disable.
- Re-enable while still draining a WRITE: honoured after the return to IDLE, starting at index 0.
- len change making index >= new len: the next advance wraps index to 0.
- busy = (FSM != IDLE); combinational from state register.
- Async reset mid-transfer: bus outputs go to reset values immediately.

Test Plan:
- Reset: assert reset_n=0 mid-WRITE -> m_chipselect=0, m_write_n=1, all readdata 0 after release.
- Cyclic run: PATTERN={0x01,0x02,0x04,0x08}, PERIOD=3, CONTROL=0x0D (en, len=4) -> PIO writes 01,02,04,08,01… exactly 4 cycles apart; first write 1 cycle after the CONTROL write.
- Oneshot: CONTROL=0x07 (en, oneshot, len=2), PERIOD=0 -> writes PAT0 then PAT1 2 cycles apart; then IDLE, STATUS=0x02 (done, index 0); write to STATUS clears done.
- Stall: hold m_waitrequest=1 for 5 cycles on the 2nd write -> m_writedata/strobes stable for those cycles; spacing counted from acceptance.
- Disable mid-run: clear enable during a stalled WRITE -> transfer completes, no further writes, busy falls the cycle after acceptance.
- Live update: change PERIOD 3->7 and PATTERN[2]=0xAA during WAIT -> next spacing stays 4; following spacing is 8; entry 2 writes 0xAA.
